// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared types and default widths for the pmem arbiter
package pmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;
    localparam int DEF_BE_W   = DEF_LINE_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_ICACHE,
        REQ_DCACHE
    } requester_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin pick, combinational
module rr_arb2
    import pmem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  requester_t last_grant,
    output logic [1:0] grant
);

    // grant[0] = icache, grant[1] = dcache
    always_comb begin
        grant = 2'b00;
        if (req_i && req_d) begin
            grant = (last_grant == REQ_ICACHE) ? 2'b10 : 2'b01;
        end else if (req_d) begin
            grant = 2'b10;
        end else if (req_i) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - shares one cacheline adaptor port between icache and dcache
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int BE_W   = DEF_BE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    input  logic [BE_W-1:0]   d_byte_enable,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic [BE_W-1:0]   pmem_byte_enable,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state, state_next;
    requester_t last_grant;
    logic [1:0] grant;
    logic       busy;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    rr_arb2 u_rr_arb2 (
        .req_i      (i_mem_read),
        .req_d      (d_mem_read | d_mem_write),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant[1]) begin
                    state_next = BUSY_D;
                end else if (grant[0]) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_mem_resp  = 1'b0;
        i_mem_rdata = '0;
        d_mem_resp  = 1'b0;
        d_mem_rdata = '0;
        if (state == BUSY_I && pmem_resp) begin
            i_mem_resp  = 1'b1;
            i_mem_rdata = pmem_rdata;
        end
        if (state == BUSY_D && pmem_resp) begin
            d_mem_resp  = 1'b1;
            d_mem_rdata = pmem_rdata;
        end
    end

    // Downstream request is captured once at grant and held until the adaptor responds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '0;
            last_grant       <= REQ_ICACHE;
        end else if (state == IDLE) begin
            if (grant[1]) begin
                pmem_read        <= d_mem_read & ~d_mem_write;
                pmem_write       <= d_mem_write;
                pmem_address     <= d_mem_address;
                pmem_wdata       <= d_mem_wdata;
                pmem_byte_enable <= d_byte_enable;
                last_grant       <= REQ_DCACHE;
            end else if (grant[0]) begin
                pmem_read        <= 1'b1;
                pmem_write       <= 1'b0;
                pmem_address     <= i_mem_address;
                pmem_wdata       <= '0;
                pmem_byte_enable <= '0;
                last_grant       <= REQ_ICACHE;
            end
        end else if (busy && pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(state == IDLE && d_mem_read && d_mem_write))
                else $warning("pmem_arbiter: dcache read and write together, read dropped");
            assert (!(pmem_resp && !busy))
                else $warning("pmem_arbiter: pmem_resp outside a transaction ignored");
        end
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - vector table, corner sequences and randomized model check for pmem_arbiter
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_mem_read;
    logic [31:0]  i_mem_address;
    logic [255:0] i_mem_rdata;
    logic         i_mem_resp;
    logic         d_mem_read;
    logic         d_mem_write;
    logic [31:0]  d_mem_address;
    logic [255:0] d_mem_wdata;
    logic [31:0]  d_byte_enable;
    logic [255:0] d_mem_rdata;
    logic         d_mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [31:0]  pmem_byte_enable;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    pmem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_mem_read       (i_mem_read),
        .i_mem_address    (i_mem_address),
        .i_mem_rdata      (i_mem_rdata),
        .i_mem_resp       (i_mem_resp),
        .d_mem_read       (d_mem_read),
        .d_mem_write      (d_mem_write),
        .d_mem_address    (d_mem_address),
        .d_mem_wdata      (d_mem_wdata),
        .d_byte_enable    (d_byte_enable),
        .d_mem_rdata      (d_mem_rdata),
        .d_mem_resp       (d_mem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit           i_rd;
        bit           d_rd;
        bit           d_wr;
        logic [31:0]  i_addr;
        logic [31:0]  d_addr;
        logic [255:0] wdata;
        logic [31:0]  be;
        logic [255:0] rdata;
        int           lat;
        bit           exp_d;
        bit           exp_rd;
        bit           exp_wr;
        logic [31:0]  exp_addr;
        logic [255:0] exp_wdata;
        logic [31:0]  exp_be;
    } txn_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    txn_t vecs[10];
    bit model_last_d;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic txn_t mk(bit i_rd, bit d_rd, bit d_wr, logic [31:0] ia, logic [31:0] da,
                                logic [255:0] wd, logic [31:0] be, logic [255:0] rd, int lat,
                                bit ed, bit erd, bit ewr, logic [31:0] eaddr,
                                logic [255:0] ewd, logic [31:0] ebe);
        txn_t t;
        t.i_rd = i_rd; t.d_rd = d_rd; t.d_wr = d_wr; t.i_addr = ia; t.d_addr = da;
        t.wdata = wd; t.be = be; t.rdata = rd; t.lat = lat;
        t.exp_d = ed; t.exp_rd = erd; t.exp_wr = ewr; t.exp_addr = eaddr;
        t.exp_wdata = ewd; t.exp_be = ebe;
        return t;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drop_reqs();
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
    endtask

    // Called #1 after an edge with the arbiter idle; returns #1 after the edge into the next idle cycle.
    task automatic run_txn(input txn_t v, input string tag);
        i_mem_read    = v.i_rd;
        d_mem_read    = v.d_rd;
        d_mem_write   = v.d_wr;
        i_mem_address = v.i_addr;
        d_mem_address = v.d_addr;
        d_mem_wdata   = v.wdata;
        d_byte_enable = v.be;
        @(posedge clk); #1;
        chk({tag, ".rd"},   pmem_read, v.exp_rd);
        chk({tag, ".wr"},   pmem_write, v.exp_wr);
        chk({tag, ".addr"}, pmem_address, v.exp_addr);
        chk({tag, ".wdat"}, pmem_wdata, v.exp_wdata);
        chk({tag, ".be"},   pmem_byte_enable, v.exp_be);
        i_mem_address = 32'hDEAD_0000;
        d_mem_address = 32'hDEAD_0000;
        d_mem_wdata   = ~v.wdata;
        d_byte_enable = ~v.be;
        for (int c = 0; c < v.lat; c++) begin
            @(posedge clk); #1;
        end
        chk({tag, ".hold_addr"}, pmem_address, v.exp_addr);
        chk({tag, ".hold_wdat"}, pmem_wdata, v.exp_wdata);
        chk({tag, ".hold_rd"},   pmem_read, v.exp_rd);
        pmem_resp  = 1'b1;
        pmem_rdata = v.rdata;
        #1;
        chk({tag, ".iresp"}, i_mem_resp, !v.exp_d);
        chk({tag, ".dresp"}, d_mem_resp, v.exp_d);
        chk({tag, ".irdat"}, i_mem_rdata, v.exp_d ? 256'd0 : v.rdata);
        chk({tag, ".drdat"}, d_mem_rdata, v.exp_d ? v.rdata : 256'd0);
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        drop_reqs();
        #1;
        chk({tag, ".done_rd"}, {pmem_read, pmem_write}, 2'b00);
        chk({tag, ".done_resp"}, {i_mem_resp, d_mem_resp}, 2'b00);
        chk({tag, ".done_rdat"}, i_mem_rdata | d_mem_rdata, 256'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [255:0] a5_line;
        logic [255:0] w1234;
        txn_t t;

        a5_line = {32{8'hA5}};
        w1234   = {8{32'h1234_5678}};

        rst = 1'b1;
        drop_reqs();
        i_mem_address = 32'h0;
        d_mem_address = 32'h0;
        d_mem_wdata   = '0;
        d_byte_enable = '0;
        pmem_rdata    = {8{32'hCAFE_F00D}};
        pmem_resp     = 1'b0;

        vecs[0] = mk(1, 1, 0, 32'h0000_1100, 32'h0000_2000, w1234, 32'hFFFF_FFFF, ~a5_line, 2,
                     1, 1, 0, 32'h0000_2000, w1234, 32'hFFFF_FFFF);
        vecs[1] = mk(1, 1, 0, 32'h0000_1140, 32'h0000_2040, w1234, 32'h0000_FFFF, a5_line, 1,
                     0, 1, 0, 32'h0000_1140, 256'd0, 32'h0);
        vecs[2] = mk(1, 1, 1, 32'h0000_1180, 32'h0000_2080, ~w1234, 32'h00FF_00FF, a5_line, 3,
                     1, 0, 1, 32'h0000_2080, ~w1234, 32'h00FF_00FF);
        vecs[3] = mk(1, 1, 0, 32'h0000_11C0, 32'h0000_20C0, w1234, 32'h1, ~a5_line, 0,
                     0, 1, 0, 32'h0000_11C0, 256'd0, 32'h0);
        vecs[4] = mk(1, 0, 1, 32'h0000_1200, 32'h0000_2100, w1234, 32'h8000_0000, a5_line, 2,
                     1, 0, 1, 32'h0000_2100, w1234, 32'h8000_0000);
        vecs[5] = mk(1, 1, 0, 32'h0000_1240, 32'h0000_2140, w1234, 32'hF, a5_line, 1,
                     0, 1, 0, 32'h0000_1240, 256'd0, 32'h0);
        vecs[6] = mk(1, 0, 0, 32'h0000_1000, 32'h0000_3000, w1234, 32'hFFFF_FFFF, a5_line, 4,
                     0, 1, 0, 32'h0000_1000, 256'd0, 32'h0);
        vecs[7] = mk(0, 0, 1, 32'h0000_1000, 32'h8000_0040, w1234, 32'hFFFF_FFFF, ~a5_line, 3,
                     1, 0, 1, 32'h8000_0040, w1234, 32'hFFFF_FFFF);
        vecs[8] = mk(0, 1, 1, 32'h0000_1000, 32'h0000_3000, ~w1234, 32'h0F0F_0F0F, a5_line, 1,
                     1, 0, 1, 32'h0000_3000, ~w1234, 32'h0F0F_0F0F);
        vecs[9] = mk(0, 1, 0, 32'h0000_1000, 32'h0000_4000, w1234, 32'h3C3C_3C3C, ~a5_line, 2,
                     1, 1, 0, 32'h0000_4000, w1234, 32'h3C3C_3C3C);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.pmem_ctl", {pmem_read, pmem_write}, 2'b00);
        chk("rst.pmem_addr", pmem_address, 32'h0);
        chk("rst.pmem_wdat", pmem_wdata, 256'd0);
        chk("rst.pmem_be", pmem_byte_enable, 32'h0);
        chk("rst.resp", {i_mem_resp, d_mem_resp}, 2'b00);
        chk("rst.rdata", i_mem_rdata | d_mem_rdata, 256'd0);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) run_txn(vecs[n], $sformatf("vec%0d", n));

        // Spurious adaptor response with nothing pending
        pmem_resp = 1'b1;
        #1;
        chk("spur.resp", {i_mem_resp, d_mem_resp}, 2'b00);
        chk("spur.rdata", i_mem_rdata | d_mem_rdata, 256'd0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("spur.idle", {pmem_read, pmem_write}, 2'b00);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an icache transaction
        i_mem_read    = 1'b1;
        i_mem_address = 32'h0000_5000;
        @(posedge clk); #1;
        chk("arst.pre_rd", pmem_read, 1'b1);
        chk("arst.pre_addr", pmem_address, 32'h0000_5000);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.rd", {pmem_read, pmem_write}, 2'b00);
        chk("arst.addr", pmem_address, 32'h0);
        drop_reqs();
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(mk(1, 1, 0, 32'h0000_6000, 32'h0000_7000, w1234, 32'hFFFF_FFFF, a5_line, 1,
                   1, 1, 0, 32'h0000_7000, w1234, 32'hFFFF_FFFF), "arst.post");

        // Randomized traffic against a grant-order model
        model_last_d = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bit ri, rd, kd;
            int kind;
            ri = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 1) == 1;
            if (!ri && !rd) ri = 1'b1;
            kind = $urandom_range(0, 2);
            t.i_rd   = ri;
            t.d_rd   = rd && (kind != 1);
            t.d_wr   = rd && (kind != 0);
            t.i_addr = $urandom & 32'hFFFF_FFE0;
            t.d_addr = $urandom & 32'hFFFF_FFE0;
            t.wdata  = rand_line();
            t.be     = $urandom;
            t.rdata  = rand_line();
            t.lat    = $urandom_range(0, 5);
            kd = (ri && rd) ? !model_last_d : rd;
            model_last_d = kd;
            t.exp_d     = kd;
            t.exp_wr    = kd && t.d_wr;
            t.exp_rd    = kd ? !t.d_wr : 1'b1;
            t.exp_addr  = kd ? t.d_addr : t.i_addr;
            t.exp_wdata = kd ? t.wdata : 256'd0;
            t.exp_be    = kd ? t.be : 32'h0;
            run_txn(t, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
